// File: rtl/sb_req_arb_if.sv
// Requester-side and scoreboard-side handshake bundle for the scoreboard request arbiter.
// master is the arbiter's view; slave is the view of the requesters and the scoreboard.
interface sb_req_arb_if #(
  parameter int width   = 8,
  parameter int asz     = 6,
  parameter int txid_sz = 2,
  parameter int reqs    = 4
);
  logic [reqs-1:0]       req_srdy;
  logic [reqs-1:0]       req_drdy;
  logic [reqs-1:0]       req_type;
  logic [reqs*width-1:0] req_mask;
  logic [reqs*width-1:0] req_data;
  logic [reqs*asz-1:0]   req_itemid;

  logic                  c_srdy;
  logic                  c_drdy;
  logic                  c_req_type;
  logic [txid_sz-1:0]    c_txid;
  logic [width-1:0]      c_mask;
  logic [width-1:0]      c_data;
  logic [asz-1:0]        c_itemid;

  logic                  p_srdy;
  logic                  p_drdy;
  logic [txid_sz-1:0]    p_txid;
  logic [width-1:0]      p_data;

  logic [reqs-1:0]       rsp_srdy;
  logic [reqs-1:0]       rsp_drdy;
  logic [width-1:0]      rsp_data;

  modport master (
    input  req_srdy, req_type, req_mask, req_data, req_itemid,
    input  c_drdy, p_srdy, p_txid, p_data, rsp_drdy,
    output req_drdy, c_srdy, c_req_type, c_txid, c_mask, c_data, c_itemid,
    output p_drdy, rsp_srdy, rsp_data
  );

  modport slave (
    output req_srdy, req_type, req_mask, req_data, req_itemid,
    output c_drdy, p_srdy, p_txid, p_data, rsp_drdy,
    input  req_drdy, c_srdy, c_req_type, c_txid, c_mask, c_data, c_itemid,
    input  p_drdy, rsp_srdy, rsp_data
  );
endinterface

// File: rtl/sb_req_arb.sv
// Round-robin arbiter sharing the scoreboard command port among requesters, with
// per-requester outstanding-read limits and txid-based response routing.
module sb_req_arb #(
  parameter int width   = 8,
  parameter int items   = 64,
  parameter int asz     = $clog2(items),
  parameter int txid_sz = 2,
  parameter int reqs    = 4,
  parameter int max_out = 4,
  parameter int csz     = $clog2(max_out + 1)
) (
  input  logic clk,
  input  logic reset,
  sb_req_arb_if.master bus,
  output logic err_unexp
);
  localparam logic [csz-1:0] max_cnt = csz'(max_out);

  logic [csz-1:0]     cnt [reqs];
  logic [txid_sz-1:0] rr_ptr;
  logic               c_srdy_q;
  logic               c_type_q;
  logic [txid_sz-1:0] c_txid_q;
  logic [width-1:0]   c_mask_q;
  logic [width-1:0]   c_data_q;
  logic [asz-1:0]     c_itemid_q;

  logic [reqs-1:0]    elig;
  logic               grant_vld;
  logic [txid_sz-1:0] grant_idx;
  logic               sel_type;
  logic [width-1:0]   sel_mask;
  logic [width-1:0]   sel_data;
  logic [asz-1:0]     sel_itemid;
  int                 scan_idx;
  logic               load;
  logic               accept;
  logic [reqs-1:0]    req_drdy_c;
  logic               rsp_hit;
  logic               p_drdy_c;
  logic [reqs-1:0]    rsp_srdy_c;
  logic               rsp_fire;
  logic [reqs-1:0]    inc_v;
  logic [reqs-1:0]    dec_v;

  always_comb begin
    for (int i = 0; i < reqs; i++)
      elig[i] = bus.req_srdy[i] & (bus.req_type[i] | (cnt[i] < max_cnt));
  end

  // First eligible requester scanning upward from rr_ptr, wrapping at reqs.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    sel_type   = 1'b0;
    sel_mask   = '0;
    sel_data   = '0;
    sel_itemid = '0;
    scan_idx   = 0;
    for (int k = 0; k < reqs; k++) begin
      scan_idx = (int'(rr_ptr) + k) % reqs;
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = txid_sz'(scan_idx);
        sel_type   = bus.req_type[scan_idx];
        sel_mask   = bus.req_mask[scan_idx*width +: width];
        sel_data   = bus.req_data[scan_idx*width +: width];
        sel_itemid = bus.req_itemid[scan_idx*asz +: asz];
      end
    end
  end

  assign load   = !c_srdy_q | bus.c_drdy;
  assign accept = reset & load & grant_vld;

  always_comb begin
    req_drdy_c = '0;
    inc_v      = '0;
    for (int i = 0; i < reqs; i++) begin
      req_drdy_c[i] = accept && (grant_idx == txid_sz'(i));
      inc_v[i]      = accept && !sel_type && (grant_idx == txid_sz'(i));
    end
  end

  // Responses for an id with nothing outstanding are swallowed and flagged.
  always_comb begin
    rsp_hit    = 1'b0;
    p_drdy_c   = 1'b1;
    rsp_srdy_c = '0;
    for (int i = 0; i < reqs; i++) begin
      if (bus.p_txid == txid_sz'(i) && cnt[i] != '0) begin
        rsp_hit       = 1'b1;
        p_drdy_c      = bus.rsp_drdy[i];
        rsp_srdy_c[i] = bus.p_srdy;
      end
    end
  end

  assign rsp_fire = bus.p_srdy & p_drdy_c & rsp_hit;

  always_comb begin
    dec_v = '0;
    for (int i = 0; i < reqs; i++)
      dec_v[i] = rsp_fire && (bus.p_txid == txid_sz'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_srdy_q   <= 1'b0;
      c_type_q   <= 1'b0;
      c_txid_q   <= '0;
      c_mask_q   <= '0;
      c_data_q   <= '0;
      c_itemid_q <= '0;
      rr_ptr     <= '0;
      err_unexp  <= 1'b0;
    end else begin
      err_unexp <= bus.p_srdy & !rsp_hit;
      if (accept) begin
        c_srdy_q   <= 1'b1;
        c_type_q   <= sel_type;
        c_txid_q   <= grant_idx;
        c_mask_q   <= sel_mask;
        c_data_q   <= sel_data;
        c_itemid_q <= sel_itemid;
        rr_ptr     <= (grant_idx == txid_sz'(reqs - 1)) ? '0 : grant_idx + 1'b1;
      end else if (load) begin
        c_srdy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < reqs; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < reqs; i++) begin
        if (inc_v[i] && !dec_v[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec_v[i] && !inc_v[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign bus.req_drdy   = req_drdy_c;
  assign bus.c_srdy     = c_srdy_q;
  assign bus.c_req_type = c_type_q;
  assign bus.c_txid     = c_txid_q;
  assign bus.c_mask     = c_mask_q;
  assign bus.c_data     = c_data_q;
  assign bus.c_itemid   = c_itemid_q;
  assign bus.p_drdy     = p_drdy_c;
  assign bus.rsp_srdy   = rsp_srdy_c;
  assign bus.rsp_data   = bus.p_data;
endmodule

// File: tb/tb_sb_req_arb.sv
// Directed bench for sb_req_arb: arbitration order, output-register stall,
// outstanding-read limits, response routing and async reset.
module tb_sb_req_arb;
  localparam int width   = 8;
  localparam int items   = 64;
  localparam int asz     = 6;
  localparam int txid_sz = 2;
  localparam int reqs    = 4;

  logic clk = 1'b0;
  logic reset;
  logic err_unexp;
  int   n_chk  = 0;
  int   n_fail = 0;

  sb_req_arb_if #(.width(width), .asz(asz), .txid_sz(txid_sz), .reqs(reqs)) bus ();

  sb_req_arb #(.width(width), .items(items), .txid_sz(txid_sz), .reqs(reqs)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_srdy   = '0;
    bus.req_type   = '0;
    bus.req_mask   = '0;
    bus.req_data   = '0;
    bus.req_itemid = '0;
    bus.c_drdy     = 1'b0;
    bus.p_srdy     = 1'b0;
    bus.p_txid     = '0;
    bus.p_data     = '0;
    bus.rsp_drdy   = '0;
  endtask

  task automatic set_req(input int i, input logic typ, input logic [asz-1:0] id,
                         input logic [width-1:0] data, input logic [width-1:0] mask);
    bus.req_type[i]                  = typ;
    bus.req_itemid[i*asz +: asz]     = id;
    bus.req_data[i*width +: width]   = data;
    bus.req_mask[i*width +: width]   = mask;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [1:0] g;
    reset = 1'b0;
    clear_inputs();
    bus.req_srdy = 4'b1111;
    repeat (2) tick();
    chk("rst_c_srdy", bus.c_srdy, 0);
    chk("rst_req_drdy", bus.req_drdy, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_c_data", bus.c_data, 0);
    bus.req_srdy = '0;
    reset = 1'b1;
    tick();

    // single write from requester 1
    bus.c_drdy = 1'b1;
    set_req(1, 1'b1, 6'd5, 8'hA5, 8'hFF);
    bus.req_srdy = 4'b0010;
    #1 chk("wr_req_drdy", bus.req_drdy, 4'b0010);
    tick();
    bus.req_srdy = '0;
    chk("wr_c_srdy", bus.c_srdy, 1);
    chk("wr_c_txid", bus.c_txid, 1);
    chk("wr_c_itemid", bus.c_itemid, 5);
    chk("wr_c_data", bus.c_data, 8'hA5);
    chk("wr_c_mask", bus.c_mask, 8'hFF);
    chk("wr_c_type", bus.c_req_type, 1);
    chk("wr_cnt1", dut.cnt[1], 0);
    tick();
    chk("idle_c_srdy", bus.c_srdy, 0);

    // all four read continuously: grants rotate 0,1,2,3,0
    do_reset();
    bus.c_drdy = 1'b1;
    for (int i = 0; i < reqs; i++) set_req(i, 1'b0, 6'(10 + i), 8'(8'h10 + i), 8'(8'hF0 | i));
    bus.req_srdy = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k % 4);
      #1 chk("rr_req_drdy", bus.req_drdy, 4'b0001 << g);
      tick();
      chk("rr_c_txid", bus.c_txid, g);
      chk("rr_c_itemid", bus.c_itemid, 10 + g);
    end
    chk("rr_cnt0", dut.cnt[0], 2);
    chk("rr_cnt3", dut.cnt[3], 1);

    // stall with register full
    bus.c_drdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_req_drdy", bus.req_drdy, 0);
      chk("stall_c_srdy", bus.c_srdy, 1);
      chk("stall_c_txid", bus.c_txid, 0);
      chk("stall_c_data", bus.c_data, 8'h10);
      chk("stall_c_mask", bus.c_mask, 8'hF0);
      tick();
    end
    bus.c_drdy = 1'b1;
    #1 chk("unstall_req_drdy", bus.req_drdy, 4'b0010);
    tick();
    chk("unstall_c_txid", bus.c_txid, 1);
    chk("unstall_cnt1", dut.cnt[1], 2);
    bus.req_srdy = '0;

    // requester 2 read limit
    do_reset();
    bus.c_drdy = 1'b1;
    set_req(2, 1'b0, 6'd33, 8'h5A, 8'h0F);
    bus.req_srdy = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1 chk("lim_req_drdy", bus.req_drdy, 4'b0100);
      tick();
    end
    chk("lim_cnt2_full", dut.cnt[2], 4);
    #1 chk("lim_blocked", bus.req_drdy, 0);
    tick();
    chk("lim_c_srdy_drop", bus.c_srdy, 0);
    bus.req_type[2] = 1'b1;
    #1 chk("lim_write_ok", bus.req_drdy, 4'b0100);
    tick();
    chk("lim_write_type", bus.c_req_type, 1);
    chk("lim_cnt2_wr", dut.cnt[2], 4);
    bus.req_type[2] = 1'b0;
    bus.p_srdy = 1'b1;
    bus.p_txid = 2'd2;
    bus.p_data = 8'h3C;
    bus.rsp_drdy = 4'b0000;
    #1 chk("rsp_bp_p_drdy", bus.p_drdy, 0);
    chk("rsp_bp_rsp_srdy", bus.rsp_srdy, 4'b0100);
    tick();
    chk("rsp_bp_cnt2", dut.cnt[2], 4);
    bus.rsp_drdy = 4'b0100;
    #1 chk("rsp_p_drdy", bus.p_drdy, 1);
    chk("rsp_rsp_srdy", bus.rsp_srdy, 4'b0100);
    chk("rsp_data", bus.rsp_data, 8'h3C);
    chk("rsp_still_blocked", bus.req_drdy, 0);
    tick();
    bus.p_srdy = 1'b0;
    chk("rsp_cnt2", dut.cnt[2], 3);
    chk("rsp_no_err", err_unexp, 0);
    #1 chk("rsp_regrant", bus.req_drdy, 4'b0100);
    tick();
    chk("rsp_cnt2_refull", dut.cnt[2], 4);
    bus.req_srdy = '0;

    // unexpected response for requester 3
    bus.p_srdy = 1'b1;
    bus.p_txid = 2'd3;
    bus.rsp_drdy = 4'b1111;
    #1 chk("unexp_p_drdy", bus.p_drdy, 1);
    chk("unexp_rsp_srdy", bus.rsp_srdy, 0);
    tick();
    bus.p_srdy = 1'b0;
    chk("unexp_err_hi", err_unexp, 1);
    chk("unexp_cnt3", dut.cnt[3], 0);
    tick();
    chk("unexp_err_lo", err_unexp, 0);

    // simultaneous accept and response on requester 0
    do_reset();
    bus.c_drdy = 1'b1;
    set_req(0, 1'b0, 6'd1, 8'h11, 8'h22);
    bus.req_srdy = 4'b0001;
    repeat (2) tick();
    chk("sim_cnt0_pre", dut.cnt[0], 2);
    bus.p_srdy = 1'b1;
    bus.p_txid = 2'd0;
    bus.rsp_drdy = 4'b0001;
    #1 chk("sim_req_drdy", bus.req_drdy, 4'b0001);
    chk("sim_p_drdy", bus.p_drdy, 1);
    tick();
    bus.p_srdy = 1'b0;
    bus.req_srdy = '0;
    chk("sim_cnt0", dut.cnt[0], 2);

    // async reset mid-burst
    do_reset();
    bus.c_drdy = 1'b1;
    for (int i = 0; i < reqs; i++) set_req(i, 1'b0, 6'(i), 8'(i), 8'hFF);
    bus.req_srdy = 4'b1111;
    repeat (2) tick();
    chk("ar_c_srdy_pre", bus.c_srdy, 1);
    chk("ar_cnt1_pre", dut.cnt[1], 1);
    #2 reset = 1'b0;
    #1 chk("ar_c_srdy", bus.c_srdy, 0);
    chk("ar_cnt0", dut.cnt[0], 0);
    chk("ar_cnt1", dut.cnt[1], 0);
    chk("ar_req_drdy", bus.req_drdy, 0);
    chk("ar_c_txid", bus.c_txid, 0);
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
